ram_access_arbiter: RTL and testbench

- Round-robin controller that shares one byte-addressed multi-width RAM between two requesters, A and B.
- Accepts one request at a time over a valid/ready handshake.
- Checks size/alignment/bounds, then drives the RAM write or read for one cycle.
- Returns read data or an error on a per-requester response channel and keeps saturating exception counters.

---
 rtl/ram_access_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one byte-addressed multi-width RAM between requesters A and B.
// One transaction in flight at a time: IDLE (grant) -> EXEC (RAM access) -> RESP (hold response).
module ram_access_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_req_valid,
    output logic                    a_req_ready,
    input  logic                    a_req_we,
    input  logic [1:0]              a_req_size,
    input  logic [ADDR_WIDTH-1:0]   a_req_addr,
    input  logic [4*DATA_WIDTH-1:0] a_req_wdata,
    output logic                    a_rsp_valid,
    input  logic                    a_rsp_ready,
    output logic [4*DATA_WIDTH-1:0] a_rsp_rdata,
    output logic                    a_rsp_err,
    input  logic                    b_req_valid,
    output logic                    b_req_ready,
    input  logic                    b_req_we,
    input  logic [1:0]              b_req_size,
    input  logic [ADDR_WIDTH-1:0]   b_req_addr,
    input  logic [4*DATA_WIDTH-1:0] b_req_wdata,
    output logic                    b_rsp_valid,
    input  logic                    b_rsp_ready,
    output logic [4*DATA_WIDTH-1:0] b_rsp_rdata,
    output logic                    b_rsp_err,
    output logic                    ram_w_en,
    output logic [1:0]              ram_select,
    output logic [ADDR_WIDTH-1:0]   ram_w_addr,
    output logic [ADDR_WIDTH-1:0]   ram_r_addr,
    output logic [4*DATA_WIDTH-1:0] ram_w_data,
    input  logic [4*DATA_WIDTH-1:0] ram_r_data,
    input  logic                    cnt_clr,
    output logic [7:0]              wr_err_count,
    output logic [7:0]              rd_err_count
);
    localparam int unsigned BusW = 4 * DATA_WIDTH;
    localparam int unsigned EndW = ADDR_WIDTH + 3;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;
    state_e state_q, state_d;

    logic                  last_grant_q;  // 0 = A, 1 = B
    logic                  owner_q;
    logic                  we_q;
    logic                  err_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BusW-1:0]       wdata_q;
    logic [BusW-1:0]       rdata_q;
    logic [7:0]            wr_cnt_q;
    logic [7:0]            rd_cnt_q;

    logic            grant_a, grant_b, accept, legal, aligned;
    logic [EndW-1:0] nbytes, end_addr;
    logic [BusW-1:0] rd_mask;

    // Ready is withheld while reset is asserted so no handshake can be seen during reset.
    assign grant_a = rst_n && a_req_valid && (!b_req_valid || last_grant_q);
    assign grant_b = rst_n && b_req_valid && (!a_req_valid || !last_grant_q);
    assign accept  = (state_q == StIdle) && (grant_a || grant_b);

    always_comb begin
        nbytes  = '0;
        aligned = 1'b0;
        rd_mask = '0;
        unique case (size_q)
            2'b00: begin
                nbytes                  = EndW'(1);
                aligned                 = 1'b1;
                rd_mask[DATA_WIDTH-1:0] = '1;
            end
            2'b01: begin
                nbytes                    = EndW'(2);
                aligned                   = ~addr_q[0];
                rd_mask[2*DATA_WIDTH-1:0] = '1;
            end
            2'b10: begin
                nbytes  = EndW'(4);
                aligned = (addr_q[1:0] == 2'b00);
                rd_mask = '1;
            end
            default: ;
        endcase
        end_addr = EndW'(addr_q) + nbytes;
        legal    = (size_q != 2'b11) && aligned && (end_addr <= EndW'(DEPTH));
    end

    always_comb begin
        state_d     = state_q;
        a_req_ready = 1'b0;
        b_req_ready = 1'b0;
        a_rsp_valid = 1'b0;
        b_rsp_valid = 1'b0;
        ram_w_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                a_req_ready = grant_a;
                b_req_ready = grant_b;
                if (accept) state_d = StExec;
            end
            StExec: begin
                ram_w_en = we_q && legal;
                state_d  = StResp;
            end
            StResp: begin
                a_rsp_valid = !owner_q;
                b_rsp_valid = owner_q;
                if (owner_q ? b_rsp_ready : a_rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q      <= grant_b;
                last_grant_q <= grant_b;
                we_q         <= grant_b ? b_req_we : a_req_we;
                size_q       <= grant_b ? b_req_size : a_req_size;
                addr_q       <= grant_b ? b_req_addr : a_req_addr;
                wdata_q      <= grant_b ? b_req_wdata : a_req_wdata;
            end
            if (state_q == StExec) begin
                err_q   <= !legal;
                rdata_q <= (legal && !we_q) ? (ram_r_data & rd_mask) : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (cnt_clr) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (state_q == StExec && !legal) begin
            if (we_q && wr_cnt_q != 8'hFF) wr_cnt_q <= wr_cnt_q + 8'd1;
            if (!we_q && rd_cnt_q != 8'hFF) rd_cnt_q <= rd_cnt_q + 8'd1;
        end
    end

    assign a_rsp_rdata  = a_rsp_valid ? rdata_q : '0;
    assign b_rsp_rdata  = b_rsp_valid ? rdata_q : '0;
    assign a_rsp_err    = a_rsp_valid && err_q;
    assign b_rsp_err    = b_rsp_valid && err_q;
    assign ram_select   = size_q;
    assign ram_w_addr   = addr_q;
    assign ram_r_addr   = addr_q;
    assign ram_w_data   = wdata_q;
    assign wr_err_count = wr_cnt_q;
    assign rd_err_count = rd_cnt_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter: byte-array RAM model plus a transaction-level
// reference model of legality, memory contents and error counters.
module tb_ram_access_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [1:0]  a_req_size, b_req_size, ram_select;
    logic [4:0]  a_req_addr, b_req_addr, ram_w_addr, ram_r_addr;
    logic [31:0] a_req_wdata, b_req_wdata, a_rsp_rdata, b_rsp_rdata, ram_w_data, ram_r_data;
    logic        ram_w_en, cnt_clr;
    logic [7:0]  wr_err_count, rd_err_count;

    int total = 0;
    int passed = 0;
    int wen_count = 0;
    int exp_wr = 0;
    int exp_rd = 0;

    logic [7:0]  ram_mem [32] = '{default: 8'h00};
    logic [7:0]  ref_mem [32] = '{default: 8'h00};
    logic [31:0] junk = 32'h0;
    int          rd_n;
    logic [31:0] rd_d;

    always #5 clk = ~clk;

    ram_access_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_size(a_req_size), .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
        .a_rsp_err(a_rsp_err),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_size(b_req_size), .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
        .b_rsp_err(b_rsp_err),
        .ram_w_en(ram_w_en), .ram_select(ram_select), .ram_w_addr(ram_w_addr),
        .ram_r_addr(ram_r_addr), .ram_w_data(ram_w_data), .ram_r_data(ram_r_data),
        .cnt_clr(cnt_clr), .wr_err_count(wr_err_count), .rd_err_count(rd_err_count)
    );

    // RAM: MSB-first packing, right-justified reads with random junk above the selected width.
    always @(posedge clk) begin
        junk <= $urandom;
        if (ram_w_en) wen_count <= wen_count + 1;
        if (ram_w_en && ram_select != 2'b11)
            for (int i = 0; i < (1 << ram_select); i++)
                if (int'(ram_w_addr) + i < 32)
                    ram_mem[int'(ram_w_addr) + i] <= ram_w_data[8*((1 << ram_select) - 1 - i) +: 8];
    end

    always_comb begin
        rd_n = (ram_select == 2'b11) ? 4 : (1 << ram_select);
        rd_d = '0;
        for (int i = 0; i < rd_n; i++) rd_d = (rd_d << 8) | 32'(ram_mem[(int'(ram_r_addr) + i) % 32]);
        ram_r_data = (rd_n == 4) ? rd_d : (rd_d | (junk & ~((32'd1 << (8 * rd_n)) - 32'd1)));
    end

    function automatic logic [31:0] ref_read(input int addr, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) r = (r << 8) | 32'(ref_mem[addr + i]);
        return r;
    endfunction

    function automatic void model(input bit we, input logic [1:0] size, input logic [4:0] addr,
                                  input logic [31:0] wd, output logic [31:0] er, output logic ee);
        int n = 1 << size;
        int a = int'(addr);
        er = '0;
        ee = !(size != 2'b11 && (a % n) == 0 && a + n <= 32);
        if (ee) begin
            if (we) exp_wr = (exp_wr >= 255) ? 255 : exp_wr + 1;
            else    exp_rd = (exp_rd >= 255) ? 255 : exp_rd + 1;
        end else if (we) begin
            for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*(n-1-i) +: 8];
        end else begin
            er = ref_read(a, n);
        end
    endfunction

    task automatic drive_req(input bit who, input bit v, input bit we, input logic [1:0] size,
                             input logic [4:0] addr, input logic [31:0] wd);
        if (who) begin
            b_req_valid = v; b_req_we = we; b_req_size = size; b_req_addr = addr; b_req_wdata = wd;
        end else begin
            a_req_valid = v; a_req_we = we; a_req_size = size; a_req_addr = addr; a_req_wdata = wd;
        end
    endtask

    // Called at a falling edge; returns at a falling edge after the response is consumed.
    // lat counts cycles from the handshake cycle to the first rsp_valid cycle.
    task automatic xact(input bit who, input bit we, input logic [1:0] size, input logic [4:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
        int n = 0;
        drive_req(who, 1'b1, we, size, addr, wd);
        #1;
        while (!(who ? b_req_ready : a_req_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        drive_req(who, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
        #1;
        lat = 1;
        while (!(who ? b_rsp_valid : a_rsp_valid) && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        rd = who ? b_rsp_rdata : a_rsp_rdata;
        er = who ? b_rsp_err : a_rsp_err;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        total++; if (a_req_ready !== 1'b0 || b_req_ready !== 1'b0) $display("FAIL reset_ready: got %b%b want 00", a_req_ready, b_req_ready); else passed++;
        total++; if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b%b want 00", a_rsp_valid, b_rsp_valid); else passed++;
        total++; if (a_rsp_err !== 1'b0 || b_rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b%b want 00", a_rsp_err, b_rsp_err); else passed++;
        total++; if (ram_w_en !== 1'b0 || ram_select !== 2'b00) $display("FAIL reset_ram_ctl: got w_en=%b sel=%b want 0/00", ram_w_en, ram_select); else passed++;
        total++; if (ram_w_addr !== 5'd0 || ram_r_addr !== 5'd0 || ram_w_data !== 32'h0) $display("FAIL reset_ram_bus: got %h %h %h want 0", ram_w_addr, ram_r_addr, ram_w_data); else passed++;
        total++; if (wr_err_count !== 8'd0 || rd_err_count !== 8'd0) $display("FAIL reset_counts: got %0d %0d want 0 0", wr_err_count, rd_err_count); else passed++;
        total++; if (a_rsp_rdata !== 32'h0 || b_rsp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h %h want 0", a_rsp_rdata, b_rsp_rdata); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_rw();
        logic [31:0] rd, er; logic e, ee; int lat, w0;
        w0 = wen_count;
        xact(1'b0, 1'b1, 2'b10, 5'd0, 32'hDEADBEEF, rd, e, lat);
        model(1'b1, 2'b10, 5'd0, 32'hDEADBEEF, er, ee);
        total++; if (e !== 1'b0 || lat != 2) $display("FAIL word_write: got err=%b lat=%0d want 0/2", e, lat); else passed++;
        total++; if (wen_count - w0 != 1) $display("FAIL word_write_pulse: got %0d pulses want 1", wen_count - w0); else passed++;
        w0 = wen_count;
        xact(1'b0, 1'b0, 2'b10, 5'd0, 32'h0, rd, e, lat);
        model(1'b0, 2'b10, 5'd0, 32'h0, er, ee);
        total++; if (rd !== 32'hDEADBEEF || e !== 1'b0) $display("FAIL word_read: got %h err=%b want deadbeef/0", rd, e); else passed++;
        total++; if (lat != 2 || wen_count != w0) $display("FAIL word_read_timing: got lat=%0d pulses=%0d want 2/0", lat, wen_count - w0); else passed++;
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, er; logic e, ee; int lat, w0;
        w0 = wen_count;
        xact(1'b0, 1'b1, 2'b01, 5'd3, 32'h0000A5A5, rd, e, lat);
        model(1'b1, 2'b01, 5'd3, 32'h0000A5A5, er, ee);
        total++; if (e !== 1'b1 || rd !== 32'h0) $display("FAIL misaligned_half_write: got err=%b rd=%h want 1/0", e, rd); else passed++;
        xact(1'b0, 1'b0, 2'b10, 5'd2, 32'h0, rd, e, lat);
        model(1'b0, 2'b10, 5'd2, 32'h0, er, ee);
        total++; if (e !== 1'b1 || rd !== 32'h0) $display("FAIL misaligned_word_read: got err=%b rd=%h want 1/0", e, rd); else passed++;
        total++; if (wen_count != w0) $display("FAIL misaligned_no_write: got %0d pulses want 0", wen_count - w0); else passed++;
        total++; if (wr_err_count !== 8'(exp_wr) || rd_err_count !== 8'(exp_rd)) $display("FAIL misaligned_counts: got %0d %0d want %0d %0d", wr_err_count, rd_err_count, exp_wr, exp_rd); else passed++;
    endtask

    task automatic test_bounds();
        bit          we_t [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  sz_t [7] = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        logic [4:0]  ad_t [7] = '{5'd30, 5'd0, 5'd31, 5'd31, 5'd30, 5'd31, 5'd28};
        logic [31:0] rd, er; logic e, ee; int lat;
        for (int i = 0; i < 7; i++) begin
            xact(1'b1, we_t[i], sz_t[i], ad_t[i], 32'h1234565A, rd, e, lat);
            model(we_t[i], sz_t[i], ad_t[i], 32'h1234565A, er, ee);
            total++; if (e !== ee || rd !== er || lat != 2) $display("FAIL bounds_%0d: got err=%b rd=%h lat=%0d want %b/%h/2", i, e, rd, lat, ee, er); else passed++;
        end
    endtask

    task automatic test_alternate();
        int a_left = 4, b_left = 4, cyc = 0;
        bit order [$];
        logic [31:0] a_exp [$], b_exp [$], x;
        a_req_we = 1'b0; a_req_size = 2'b00; a_req_addr = 5'd0;  a_req_valid = 1'b1;
        b_req_we = 1'b0; b_req_size = 2'b00; b_req_addr = 5'd28; b_req_valid = 1'b1;
        while ((a_left > 0 || b_left > 0 || a_exp.size() > 0 || b_exp.size() > 0) && cyc < 200) begin
            bit a_hs, b_hs;
            #1;
            a_hs = a_req_ready;
            b_hs = b_req_ready;
            if (a_hs) begin order.push_back(1'b0); a_exp.push_back(ref_read(int'(a_req_addr), 1)); end
            if (b_hs) begin order.push_back(1'b1); b_exp.push_back(ref_read(int'(b_req_addr), 1)); end
            if (a_rsp_valid) begin
                total++;
                if (a_exp.size() == 0) $display("FAIL alt_a_owner: got A response want none outstanding");
                else begin
                    x = a_exp.pop_front();
                    if (a_rsp_rdata !== x || a_rsp_err !== 1'b0) $display("FAIL alt_a_data: got %h err=%b want %h/0", a_rsp_rdata, a_rsp_err, x); else passed++;
                end
            end
            if (b_rsp_valid) begin
                total++;
                if (b_exp.size() == 0) $display("FAIL alt_b_owner: got B response want none outstanding");
                else begin
                    x = b_exp.pop_front();
                    if (b_rsp_rdata !== x || b_rsp_err !== 1'b0) $display("FAIL alt_b_data: got %h err=%b want %h/0", b_rsp_rdata, b_rsp_err, x); else passed++;
                end
            end
            @(negedge clk);
            cyc++;
            if (a_hs) begin a_left--; a_req_addr = a_req_addr + 5'd1; if (a_left == 0) a_req_valid = 1'b0; end
            if (b_hs) begin b_left--; b_req_addr = b_req_addr + 5'd1; if (b_left == 0) b_req_valid = 1'b0; end
        end
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        total++; if (cyc >= 200 || order.size() != 8) $display("FAIL alt_progress: got %0d grants in %0d cycles want 8", order.size(), cyc); else passed++;
        for (int i = 0; i < order.size(); i++) begin
            total++; if (order[i] !== bit'(i % 2)) $display("FAIL alt_order_%0d: got %0d want %0d", i, order[i], i % 2); else passed++;
        end
    endtask

    task automatic test_stall();
        logic [31:0] ex, er; logic ee; int n = 0;
        model(1'b0, 2'b10, 5'd0, 32'h0, ex, ee);
        a_rsp_ready = 1'b0;
        drive_req(1'b0, 1'b1, 1'b0, 2'b10, 5'd0, 32'h0);
        #1;
        while (!a_req_ready && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        drive_req(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
        drive_req(1'b1, 1'b1, 1'b0, 2'b00, 5'd31, 32'h0);
        #1;
        n = 0;
        while (!a_rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            total++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== ex) $display("FAIL stall_hold_%0d: got v=%b rd=%h want 1/%h", i, a_rsp_valid, a_rsp_rdata, ex); else passed++;
            total++; if (b_req_ready !== 1'b0) $display("FAIL stall_b_ready_%0d: got %b want 0", i, b_req_ready); else passed++;
            @(negedge clk); #1;
        end
        a_rsp_ready = 1'b1;
        @(negedge clk); #1;
        total++; if (b_req_ready !== 1'b1) $display("FAIL stall_b_grant: got %b want 1", b_req_ready); else passed++;
        @(negedge clk);
        drive_req(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
        model(1'b0, 2'b00, 5'd31, 32'h0, er, ee);
        #1;
        n = 0;
        while (!b_rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
        total++; if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== er) $display("FAIL stall_b_data: got v=%b rd=%h want 1/%h", b_rsp_valid, b_rsp_rdata, er); else passed++;
        @(negedge clk);
    endtask

    task automatic test_saturate();
        logic [31:0] rd, er; logic e, ee; int lat, n = 0;
        for (int i = 0; i < 260; i++) begin
            logic [4:0] ad; logic [31:0] wd;
            ad = 5'(2 * $urandom_range(0, 14) + 1);
            wd = $urandom;
            xact(bit'(i % 2), 1'b1, 2'b01, ad, wd, rd, e, lat);
            model(1'b1, 2'b01, ad, wd, er, ee);
            total++; if (e !== 1'b1) $display("FAIL sat_err_%0d: got %b want 1", i, e); else passed++;
        end
        total++; if (wr_err_count !== 8'd255 || exp_wr != 255) $display("FAIL sat_count: got %0d want 255", wr_err_count); else passed++;
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        exp_wr = 0; exp_rd = 0;
        #1;
        total++; if (wr_err_count !== 8'd0 || rd_err_count !== 8'd0) $display("FAIL clr_pulse: got %0d %0d want 0 0", wr_err_count, rd_err_count); else passed++;
        @(negedge clk);
        // Clear held across the EXEC cycle of a rejected write must win over the increment.
        drive_req(1'b0, 1'b1, 1'b1, 2'b01, 5'd1, 32'h0);
        #1;
        while (!a_req_ready && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        drive_req(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        total++; if (wr_err_count !== 8'd0 || a_rsp_err !== 1'b1) $display("FAIL clr_priority: got cnt=%0d err=%b want 0/1", wr_err_count, a_rsp_err); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, er; logic e, ee; int lat, w0, n = 0;
        xact(1'b0, 1'b1, 2'b10, 5'd6, 32'h0, rd, e, lat);
        model(1'b1, 2'b10, 5'd6, 32'h0, er, ee);
        drive_req(1'b0, 1'b1, 1'b1, 2'b10, 5'd8, 32'h12345678);
        #1;
        while (!a_req_ready && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk); #1;
        total++; if (ram_w_en !== 1'b1 || wr_err_count !== 8'(exp_wr)) $display("FAIL mid_exec: got w_en=%b cnt=%0d want 1/%0d", ram_w_en, wr_err_count, exp_wr); else passed++;
        w0 = wen_count;
        rst_n = 1'b0;
        #1;
        total++; if (ram_w_en !== 1'b0 || a_req_ready !== 1'b0 || b_req_ready !== 1'b0) $display("FAIL mid_reset_ctl: got w_en=%b rdy=%b%b want 0/00", ram_w_en, a_req_ready, b_req_ready); else passed++;
        total++; if (ram_select !== 2'b00 || ram_w_addr !== 5'd0 || ram_r_addr !== 5'd0 || ram_w_data !== 32'h0) $display("FAIL mid_reset_bus: got %b %h %h %h want 0", ram_select, ram_w_addr, ram_r_addr, ram_w_data); else passed++;
        total++; if (a_rsp_valid !== 1'b0 || wr_err_count !== 8'd0 || rd_err_count !== 8'd0) $display("FAIL mid_reset_state: got v=%b cnt=%0d/%0d want 0/0/0", a_rsp_valid, wr_err_count, rd_err_count); else passed++;
        @(negedge clk);
        total++; if (wen_count != w0) $display("FAIL mid_reset_no_write: got %0d pulses want 0", wen_count - w0); else passed++;
        drive_req(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
        rst_n = 1'b1;
        exp_wr = 0; exp_rd = 0;
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 32'h0);
        drive_req(1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 32'h0);
        #1;
        total++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b0) $display("FAIL mid_first_grant: got %b%b want 10", a_req_ready, b_req_ready); else passed++;
        drive_req(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
        drive_req(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
        @(negedge clk);
        xact(1'b0, 1'b0, 2'b10, 5'd8, 32'h0, rd, e, lat);
        model(1'b0, 2'b10, 5'd8, 32'h0, er, ee);
        total++; if (rd !== er || e !== 1'b0) $display("FAIL mid_mem_intact: got %h err=%b want %h/0", rd, e, er); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit who, we; logic [1:0] sz; logic [4:0] ad; logic [31:0] wd, rd, er; logic e, ee;
            int lat, w0;
            who = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            ad  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) ad = ad & ~((5'd1 << sz) - 5'd1);
            wd  = $urandom;
            w0  = wen_count;
            xact(who, we, sz, ad, wd, rd, e, lat);
            model(we, sz, ad, wd, er, ee);
            total++; if (rd !== er || e !== ee || lat != 2) $display("FAIL rand_%0d: got rd=%h err=%b lat=%0d want %h/%b/2", i, rd, e, lat, er, ee); else passed++;
            total++; if (wen_count - w0 != ((we && !ee) ? 1 : 0)) $display("FAIL rand_wen_%0d: got %0d pulses want %0d", i, wen_count - w0, (we && !ee) ? 1 : 0); else passed++;
        end
        total++; if (wr_err_count !== 8'(exp_wr) || rd_err_count !== 8'(exp_rd)) $display("FAIL rand_counts: got %0d %0d want %0d %0d", wr_err_count, rd_err_count, exp_wr, exp_rd); else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cnt_clr = 1'b0;
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;
        drive_req(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
        drive_req(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
        test_reset();
        test_word_rw();
        test_misaligned();
        test_bounds();
        test_alternate();
        test_stall();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
